// File: rtl/cci_mpf_shim_rsp_buffer_c0.sv
// cci_mpf_shim_rsp_buffer_c0
//   Channel-0 read-response buffer. The QLP cannot be back-pressured, so each
//   read request reserves a FIFO slot through a credit count. Every response
//   that arrives is then guaranteed a place to land. Responses stay at the
//   head of the FIFO until the consumer dequeues them.
//   Optional feature: define CCI_MPF_RSP_BUF_BYPASS_EN to present a response
//   on first_* in its arrival cycle when the FIFO is empty (0-cycle latency).
//
// Handshake: first_*/not_empty form a valid/ready pair with deq as ready.
//   A head transfers on a cycle where not_empty && deq. While not_empty=1
//   and deq=0, first_* hold. deq with not_empty=0 is a protocol violation.
//   rx_rd_valid is a push with no ready. It must be covered by a credit taken
//   earlier with req_issue.
module cci_mpf_shim_rsp_buffer_c0 #(
   parameter int CCI_DATA_WIDTH   = 512,
   parameter int CCI_RX_HDR_WIDTH = 18,
   parameter int N_ENTRIES        = 16,
   parameter int THRESHOLD        = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_issue,
   output logic                        req_alm_full,
   input  logic [CCI_RX_HDR_WIDTH-1:0] rx_hdr,
   input  logic [CCI_DATA_WIDTH-1:0]   rx_data,
   input  logic                        rx_rd_valid,
   output logic [CCI_RX_HDR_WIDTH-1:0] first_hdr,
   output logic [CCI_DATA_WIDTH-1:0]   first_data,
   output logic                        not_empty,
   input  logic                        deq,
   output logic                        error
);

   localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int CW = $clog2(N_ENTRIES + 1);
   localparam int UW = CW + 1;
   localparam logic [PW-1:0] LAST_IDX  = PW'(N_ENTRIES - 1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [UW-1:0] FULL_USED = UW'(N_ENTRIES);
   // used at or above this level means free credits <= THRESHOLD
   localparam logic [UW-1:0] ALM_USED  = UW'(N_ENTRIES - THRESHOLD);

   logic [CCI_RX_HDR_WIDTH-1:0] hdr_mem  [N_ENTRIES];
   logic [CCI_DATA_WIDTH-1:0]   data_mem [N_ENTRIES];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] occupancy, occupancy_nxt;
   logic [CW-1:0] outstanding, outstanding_nxt;
   logic [UW-1:0] used, used_nxt;

   logic fifo_valid;
   logic rsp_ok;
   logic req_ok;
   logic bypass_take;
   logic enq;
   logic deq_fifo;
   logic violation;

   assign fifo_valid = (occupancy != '0);
   assign used       = {1'b0, outstanding} + {1'b0, occupancy};

   // A response is accepted only when it is covered by an outstanding credit
   assign rsp_ok = rx_rd_valid && (outstanding != '0);
   // A request is counted only when a credit is still free
   assign req_ok = req_issue && (used < FULL_USED);

`ifdef CCI_MPF_RSP_BUF_BYPASS_EN
   logic bypass_valid;
   // With an empty FIFO the live response is the head; a queued head always wins
   assign bypass_valid = !fifo_valid && rsp_ok;
   assign bypass_take  = bypass_valid && deq;
   assign not_empty    = fifo_valid || bypass_valid;
   assign first_hdr    = fifo_valid ? hdr_mem[rd_ptr]  : rx_hdr;
   assign first_data   = fifo_valid ? data_mem[rd_ptr] : rx_data;
`else
   assign bypass_take  = 1'b0;
   assign not_empty    = fifo_valid;
   assign first_hdr    = hdr_mem[rd_ptr];
   assign first_data   = data_mem[rd_ptr];
`endif

   assign enq       = rsp_ok && !bypass_take;
   assign deq_fifo  = deq && fifo_valid;
   assign violation = (req_issue && (used == FULL_USED)) ||
                      (rx_rd_valid && (outstanding == '0)) ||
                      (deq && !not_empty);

   // Next-state credit and occupancy counts; saturation comes from req_ok/rsp_ok
   always_comb begin
      outstanding_nxt = outstanding;
      if (req_ok && !rsp_ok) begin
         outstanding_nxt = outstanding + CNT_ONE;
      end else if (!req_ok && rsp_ok) begin
         outstanding_nxt = outstanding - CNT_ONE;
      end
      occupancy_nxt = occupancy;
      if (enq && !deq_fifo) begin
         occupancy_nxt = occupancy + CNT_ONE;
      end else if (!enq && deq_fifo) begin
         occupancy_nxt = occupancy - CNT_ONE;
      end
      used_nxt = {1'b0, outstanding_nxt} + {1'b0, occupancy_nxt};
   end

   // Response storage; contents need no reset because occupancy qualifies them
   always_ff @(posedge clk) begin
      if (enq) begin
         hdr_mem[wr_ptr]  <= rx_hdr;
         data_mem[wr_ptr] <= rx_data;
      end
   end

   // Pointers, counters and the registered status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occupancy    <= '0;
         outstanding  <= '0;
         req_alm_full <= 1'b0;
         error        <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_ONE;
         end
         if (deq_fifo) begin
            rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_ONE;
         end
         occupancy    <= occupancy_nxt;
         outstanding  <= outstanding_nxt;
         req_alm_full <= (used_nxt >= ALM_USED);
         if (violation) begin
            error <= 1'b1;
         end
      end
   end

endmodule
